// File: rtl/imem_pipe_if.sv
// Fetch-side bus for imem_pipe: request/response handshakes, flush and program-load port.
interface imem_pipe_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W+1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_misalign;
  logic              flush;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;

  // Fetch unit / loader side
  modport master (
    output req_valid, req_addr, rsp_ready, flush, ld_en, ld_addr, ld_data,
    input  req_ready, rsp_valid, rsp_data, rsp_misalign
  );

  // Memory side
  modport slave (
    input  req_valid, req_addr, rsp_ready, flush, ld_en, ld_addr, ld_data,
    output req_ready, rsp_valid, rsp_data, rsp_misalign
  );

endinterface

// File: rtl/imem_pipe.sv
// Synchronous-read instruction memory for the MIPS32 fetch stage.
// Byte-addressed fetch requests on a valid/ready handshake; the word is returned
// one cycle later from a registered response stage that honours backpressure.
// Also provides a program-load write port, misalignment flagging and a flush.
// Optional statistics counters are enabled by defining IMEM_PIPE_STATS_EN;
// without it fetch_count/stall_count are tied to zero.
module imem_pipe #(
  parameter int unsigned       ADDR_W    = 6,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [DATA_W-1:0] INIT_WORD = '0
) (
  input  logic               clk,
  input  logic               reset,
  imem_pipe_if.slave         bus,
  output logic [31:0]        fetch_count,
  output logic [31:0]        stall_count
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 32;

  // Storage; contents survive reset and start out as INIT_WORD.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: INIT_WORD};

  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_misalign_q;

  logic              ready_c;
  logic              accept_c;
  logic              misalign_c;
  logic [ADDR_W-1:0] word_idx_c;

  // Acceptance: response slot free or draining, and no flush/load/reset this cycle.
  always_comb begin
    ready_c    = !reset && !bus.flush && !bus.ld_en && (!rsp_valid_q || bus.rsp_ready);
    accept_c   = bus.req_valid && ready_c;
    misalign_c = |bus.req_addr[1:0];
    word_idx_c = bus.req_addr[ADDR_W+1:2];
  end

  assign bus.req_ready    = ready_c;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_misalign = rsp_misalign_q;

  // Program-load write port; independent of reset and flush.
  always_ff @(posedge clk) begin
    if (bus.ld_en) begin
      mem[bus.ld_addr] <= bus.ld_data;
    end
  end

  // Response stage: capture on accept, hold under backpressure, drop on flush/reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
      rsp_misalign_q <= 1'b0;
    end else if (bus.flush) begin
      rsp_valid_q    <= 1'b0;
    end else if (accept_c) begin
      rsp_valid_q    <= 1'b1;
      rsp_misalign_q <= misalign_c;
      // A misaligned fetch never reads the array.
      rsp_data_q     <= misalign_c ? INIT_WORD : mem[word_idx_c];
    end else if (bus.rsp_ready) begin
      rsp_valid_q    <= 1'b0;
    end
  end

`ifdef IMEM_PIPE_STATS_EN
  logic [CNT_W-1:0] fetch_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;

  // Accepted requests and backpressured cycles; neither counts in a flush cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else if (!bus.flush) begin
      if (accept_c) begin
        fetch_cnt_q <= fetch_cnt_q + CNT_W'(1);
      end
      if (rsp_valid_q && !bus.rsp_ready) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`else
  assign fetch_count = '0;
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_imem_pipe.sv
// Directed bench for imem_pipe with an expected-response scoreboard queue.
module tb_imem_pipe;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fetch_count;
  logic [31:0] stall_count;

  imem_pipe_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  imem_pipe #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INIT_WORD(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .fetch_count (fetch_count),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  exp_t        sb[$];
  logic [31:0] mem_m [1 << ADDR_W];
  logic [31:0] m_fetch;
  logic [31:0] m_stall;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stat_exp(input logic [31:0] v);
`ifdef IMEM_PIPE_STATS_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  task automatic drive(input logic rv, input logic [ADDR_W+1:0] addr, input logic rr,
                       input logic fl, input logic le, input logic [ADDR_W-1:0] la,
                       input logic [DATA_W-1:0] ld);
    bus.req_valid = rv;
    bus.req_addr  = addr;
    bus.rsp_ready = rr;
    bus.flush     = fl;
    bus.ld_en     = le;
    bus.ld_addr   = la;
    bus.ld_data   = ld;
  endtask

  // One clock: check the handshake and any held response, advance the model, check after the edge.
  task automatic cyc();
    logic mr;
    logic mv;
    exp_t e;
    #2;
    mv = (sb.size() != 0);
    mr = !reset && !bus.flush && !bus.ld_en && (!mv || bus.rsp_ready);
    check("req_ready", 64'(bus.req_ready), 64'(mr));
    if (mv) begin
      check("rsp_data", 64'(bus.rsp_data), 64'(sb[0].data));
      check("rsp_misalign", 64'(bus.rsp_misalign), 64'(sb[0].mis));
    end
    if (reset) begin
      sb.delete();
      m_fetch = '0;
      m_stall = '0;
    end else if (bus.flush) begin
      sb.delete();
    end else begin
      if (mv && !bus.rsp_ready) m_stall = m_stall + 32'd1;
      if (mv && bus.rsp_ready) void'(sb.pop_front());
      if (bus.req_valid && mr) begin
        e.mis  = |bus.req_addr[1:0];
        e.data = e.mis ? 32'h0 : mem_m[bus.req_addr[ADDR_W+1:2]];
        sb.push_back(e);
        m_fetch = m_fetch + 32'd1;
      end
    end
    if (bus.ld_en) mem_m[bus.ld_addr] = bus.ld_data;
    @(posedge clk);
    #1;
    check("rsp_valid", 64'(bus.rsp_valid), 64'(sb.size() != 0));
    check("fetch_count", 64'(fetch_count), 64'(stat_exp(m_fetch)));
    check("stall_count", 64'(stall_count), 64'(stat_exp(m_stall)));
  endtask

  initial begin
    foreach (mem_m[i]) mem_m[i] = 32'h0;
    m_fetch = '0;
    m_stall = '0;
    reset   = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    cyc();
    cyc();
    check("reset_rsp_data", 64'(bus.rsp_data), 64'h0);
    check("reset_rsp_misalign", 64'(bus.rsp_misalign), 64'h0);
    reset = 1'b0;

    // Load then fetch
    drive(1'b0, '0, 1'b1, 1'b0, 1'b1, 6'd3, 32'h2008_0005); cyc();
    drive(1'b1, 8'd12, 1'b1, 1'b0, 1'b0, '0, '0); cyc();
    check("load_fetch_data", 64'(bus.rsp_data), 64'h2008_0005);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0); cyc();

    // Streaming after loading words 1..4
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0, 1'b1, 6'(i), 32'(i + 1)); cyc();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(4 * i), 1'b1, 1'b0, 1'b0, '0, '0); cyc();
    end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0); cyc();

    // Backpressure: hold three cycles, then accept the next request as it drains
    drive(1'b1, 8'd4, 1'b0, 1'b0, 1'b0, '0, '0); cyc();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'd8, 1'b0, 1'b0, 1'b0, '0, '0); cyc();
    end
    check("bp_data_held", 64'(bus.rsp_data), 64'h2);
    drive(1'b1, 8'd8, 1'b1, 1'b0, 1'b0, '0, '0); cyc();
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0); cyc();

    // Misaligned fetch, then word 1 still intact
    drive(1'b1, 8'd6, 1'b1, 1'b0, 1'b0, '0, '0); cyc();
    check("misalign_flag", 64'(bus.rsp_misalign), 64'h1);
    drive(1'b1, 8'd4, 1'b1, 1'b0, 1'b0, '0, '0); cyc();
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0); cyc();

    // Flush of a held response, with a request presented in the flush cycle
    drive(1'b1, 8'd8, 1'b0, 1'b0, 1'b0, '0, '0); cyc();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0); cyc();
    drive(1'b1, 8'd0, 1'b0, 1'b1, 1'b0, '0, '0); cyc();

    // Reset of a held response; memory retained afterwards
    drive(1'b1, 8'd12, 1'b0, 1'b0, 1'b0, '0, '0); cyc();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0); cyc();
    reset = 1'b1;
    drive(1'b1, 8'd12, 1'b0, 1'b0, 1'b0, '0, '0); cyc();
    check("mid_reset_rsp_data", 64'(bus.rsp_data), 64'h0);
    reset = 1'b0;
    drive(1'b1, 8'd12, 1'b1, 1'b0, 1'b0, '0, '0); cyc();
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0); cyc();

    // Load collision: blocked, then accepted returning the new word
    drive(1'b1, 8'd20, 1'b1, 1'b0, 1'b1, 6'd5, 32'hDEAD_BEEF); cyc();
    drive(1'b1, 8'd20, 1'b1, 1'b0, 1'b0, '0, '0); cyc();
    check("collision_data", 64'(bus.rsp_data), 64'hDEAD_BEEF);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0); cyc();

    // Flush and load together: both take effect
    drive(1'b1, 8'd28, 1'b1, 1'b1, 1'b1, 6'd7, 32'h0000_1234); cyc();
    drive(1'b1, 8'd28, 1'b1, 1'b0, 1'b0, '0, '0); cyc();
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
